// File: rtl/swerv_types.sv
// ---------------------------------------------------------------------------
// swerv_types
//   Shared types for the execute-unit divider.
//   div_pkt_t   : decode-side request packet {valid, unsign, rem}
//   div_state_t : divider control states
// ---------------------------------------------------------------------------
package swerv_types;

   // Request packet from decode: valid strobe, unsigned op, return remainder
   typedef struct packed {
      logic valid;
      logic unsign;
      logic rem;
   } div_pkt_t;

   // Divider sequencing: IDLE -> ABS -> ITER x WIDTH -> FIX -> DONE -> IDLE
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ABS  = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } div_state_t;

endpackage : swerv_types

// File: rtl/exu_div_neg.sv
// ---------------------------------------------------------------------------
// exu_div_neg
//   Conditional two's-complement negate, used both to take operand magnitudes
//   and to restore the sign of quotient/remainder.
//   i_neg : negate when 1, pass through when 0
//   i_val : WIDTH-bit input value
//   o_res : i_neg ? -i_val : i_val
// ---------------------------------------------------------------------------
module exu_div_neg #(
   parameter int WIDTH = 32
) (
   input  logic             i_neg,
   input  logic [WIDTH-1:0] i_val,
   output logic [WIDTH-1:0] o_res
);

   // Plain subtraction from zero; the most negative value maps onto itself,
   // which is exactly its unsigned magnitude.
   assign o_res = i_neg ? ('0 - i_val) : i_val;

endmodule : exu_div_neg

// File: rtl/exu_div_seq.sv
// ---------------------------------------------------------------------------
// exu_div_seq
//   Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   One quotient bit per cycle; accepts a new op in IDLE or DONE.
//   clk    : clock
//   rst    : synchronous active-high reset
//   freeze : hold all state (finish pulse stretches while frozen in DONE)
//   flush  : abandon any op in flight, return to IDLE, no finish
//   dp     : request packet {valid, unsign, rem}
//   a, b   : dividend (rs1), divisor (rs2)
//   busy   : op in flight (ABS/ITER/FIX)
//   finish : result strobe, out valid while high
//   out    : quotient (rem=0) or remainder (rem=1)
// ---------------------------------------------------------------------------
module exu_div_seq
   import swerv_types::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  div_pkt_t         dp,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             finish,
   output logic [WIDTH-1:0] out
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_unsign;
   logic             r_rem;
   logic             r_signA;
   logic             r_signB;
   logic [WIDTH-1:0] r_absB;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_out;

   logic             w_signA;
   logic             w_signB;
   logic [WIDTH-1:0] w_absA;
   logic [WIDTH-1:0] w_absB;
   logic [WIDTH-1:0] w_quoFix;
   logic [WIDTH-1:0] w_remFix;
   logic [WIDTH:0]   w_t;
   logic             w_divZero;
   logic             w_ovf;
   logic [WIDTH-1:0] w_special;

   // Operand signs only matter for signed ops; magnitudes taken from the
   // latched originals so the special-case checks can still see raw values.
   assign w_signA = ~r_unsign & r_a[WIDTH-1];
   assign w_signB = ~r_unsign & r_b[WIDTH-1];

   exu_div_neg #(.WIDTH(WIDTH)) u_negA (.i_neg(w_signA), .i_val(r_a), .o_res(w_absA));
   exu_div_neg #(.WIDTH(WIDTH)) u_negB (.i_neg(w_signB), .i_val(r_b), .o_res(w_absB));

   // Quotient is negative when operand signs differ; remainder takes the
   // dividend's sign (truncating division).
   exu_div_neg #(.WIDTH(WIDTH)) u_negQ (.i_neg(r_signA ^ r_signB), .i_val(r_q), .o_res(w_quoFix));
   exu_div_neg #(.WIDTH(WIDTH)) u_negR (.i_neg(r_signA), .i_val(r_r), .o_res(w_remFix));

   // Trial subtraction. The partial remainder stays below |b|, so the shifted
   // value minus |b| is below 2^WIDTH whenever it is non-negative; the top bit
   // of w_t is therefore a clean borrow flag and r_r needs only WIDTH bits.
   assign w_t = {r_r, r_q[WIDTH-1]} - {1'b0, r_absB};

   // Divide-by-zero and signed overflow bypass the iteration entirely.
   // Overflow quotient equals the dividend itself (most negative value).
   assign w_divZero = (r_b == '0);
   assign w_ovf     = ~r_unsign & (r_a == MIN_NEG) & (r_b == '1);
   assign w_special = w_divZero ? (r_rem ? r_a : '1)
                                : (r_rem ? '0  : r_a);

   // Status outputs are pure state decodes; freeze holds the state, so a
   // frozen DONE naturally stretches the finish pulse.
   assign busy   = (r_state == S_ABS) | (r_state == S_ITER) | (r_state == S_FIX);
   assign finish = (r_state == S_DONE);
   assign out    = r_out;

   // Control and datapath registers. Priority: reset, then flush (drops the
   // op without touching out), then freeze (hold everything), then normal
   // sequencing. DONE accepts a new request just like IDLE so ops can run
   // back to back.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_unsign <= 1'b0;
         r_rem    <= 1'b0;
         r_signA  <= 1'b0;
         r_signB  <= 1'b0;
         r_absB   <= '0;
         r_r      <= '0;
         r_q      <= '0;
         r_cnt    <= '0;
         r_out    <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
      end else if (!freeze) begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (dp.valid) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_unsign <= dp.unsign;
                  r_rem    <= dp.rem;
                  r_state  <= S_ABS;
               end else begin
                  r_state  <= S_IDLE;
               end
            end
            S_ABS: begin
               r_signA <= w_signA;
               r_signB <= w_signB;
               r_absB  <= w_absB;
               r_q     <= w_absA;
               r_r     <= '0;
               r_cnt   <= '0;
               if (w_divZero | w_ovf) begin
                  r_out   <= w_special;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_ITER;
               end
            end
            S_ITER: begin
               if (!w_t[WIDTH]) begin
                  r_r <= w_t[WIDTH-1:0];
                  r_q <= {r_q[WIDTH-2:0], 1'b1};
               end else begin
                  r_r <= {r_r[WIDTH-2:0], r_q[WIDTH-1]};
                  r_q <= {r_q[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST_CNT) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_out   <= r_rem ? w_remFix : w_quoFix;
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule : exu_div_seq
